pixel_fifo: RTL and testbench

PIXEL_FIFO -- requirements
Module: pixel_fifo

---
 rtl/pixel_fifo.sv | 189 ++++++++++++++++++
 tb/tb_pixel_fifo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fifo
// Description : Single-clock word FIFO that buffers LED pixel data between the
//               host bus and a string wrapper. One simple-dual-port RAM
//               (one write port, one registered read port) holds the words;
//               pointers, word count and status flags are registered.
//
// Ports       : clk            - sole clock, rising edge
//               reset          - synchronous active-high reset
//               wr_data/wr_en  - host write word and request
//               clear          - synchronous flush of contents and flags
//               rd_en          - read request from the string wrapper
//               rd_data        - registered read word (holds when not valid)
//               rd_data_valid  - rd_data carries a freshly popped word
//               full_count     - stored word count, 0..DEPTH
//               full / empty   - count == DEPTH / count == 0
//               overflow       - sticky: write dropped because FIFO was full
//               underflow      - sticky: read attempted while FIFO was empty
//               frame_ready    - at least FRAME_WORDS words are buffered
//
// Config      : define PIXEL_FIFO_FRAME_READY_EN to build the frame_ready
//               comparator; otherwise frame_ready is tied low.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 16,
   parameter int FRAME_WORDS = 900
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   input  logic                  clear,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_valid,
   output logic [ADDR_WIDTH:0]   full_count,
   output logic                  full,
   output logic                  empty,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  frame_ready
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   c_depth_count = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   c_count_one   = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] c_ptr_one     = ADDR_WIDTH'(1);

   // Storage
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // State
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   full_count_q, full_count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  rd_data_valid_q, rd_data_valid_d;
   logic [DATA_WIDTH-1:0] rd_data_q;

   logic rd_accept;
   logic wr_accept;

   always_comb begin
      // Reset and clear both suppress any same-cycle traffic, so the RAM
      // write enable and read register enable are gated here too.
      rd_accept = rd_en && !empty_q && !clear && !reset;
      // A full FIFO still takes a write when a read frees a slot this cycle;
      // an empty FIFO never forwards the write to the read side.
      wr_accept = wr_en && (!full_q || rd_accept) && !clear && !reset;

      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      full_count_d    = full_count_q;
      overflow_d      = overflow_q;
      underflow_d     = underflow_q;
      rd_data_valid_d = rd_accept;

      if (clear) begin
         wr_ptr_d        = '0;
         rd_ptr_d        = '0;
         full_count_d    = '0;
         overflow_d      = 1'b0;
         underflow_d     = 1'b0;
         rd_data_valid_d = 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
         end
         if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
         end
         case ({wr_accept, rd_accept})
            2'b10:   full_count_d = full_count_q + c_count_one;
            2'b01:   full_count_d = full_count_q - c_count_one;
            default: full_count_d = full_count_q;
         endcase
         if (wr_en && !wr_accept) begin
            overflow_d = 1'b1;
         end
         if (rd_en && empty_q) begin
            underflow_d = 1'b1;
         end
      end

      // Flags derive from the next count so they stay coherent with it.
      full_d  = (full_count_d == c_depth_count);
      empty_d = (full_count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         full_count_q    <= '0;
         full_q          <= 1'b0;
         empty_q         <= 1'b1;
         overflow_q      <= 1'b0;
         underflow_q     <= 1'b0;
         rd_data_valid_q <= 1'b0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         full_count_q    <= full_count_d;
         full_q          <= full_d;
         empty_q         <= empty_d;
         overflow_q      <= overflow_d;
         underflow_q     <= underflow_d;
         rd_data_valid_q <= rd_data_valid_d;
      end
   end

   // RAM write port. Kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   // RAM registered read port. The read address comes straight from the
   // pointer flop (no combinational next-value path) so the output register
   // is the RAM's own; a same-address write on a full FIFO returns old data.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= '0;
      end else if (rd_accept) begin
         rd_data_q <= mem[rd_ptr_q];
      end
   end

`ifdef PIXEL_FIFO_FRAME_READY_EN
   localparam logic [ADDR_WIDTH:0] c_frame_words = (ADDR_WIDTH + 1)'(FRAME_WORDS);

   logic frame_ready_q, frame_ready_d;

   // Compares the registered count, so frame_ready lags full_count by one.
   always_comb begin
      frame_ready_d = (full_count_q >= c_frame_words);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_ready_q <= 1'b0;
      end else begin
         frame_ready_q <= frame_ready_d;
      end
   end

   assign frame_ready = frame_ready_q;
`else
   assign frame_ready = 1'b0;
`endif

   assign rd_data       = rd_data_q;
   assign rd_data_valid = rd_data_valid_q;
   assign full_count    = full_count_q;
   assign full          = full_q;
   assign empty         = empty_q;
   assign overflow      = overflow_q;
   assign underflow     = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_fifo
// Description : Self-checking bench for pixel_fifo. A queue scoreboard holds
//               every word accepted by the write side; reads pop it and the
//               popped word is compared with rd_data when it appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_fifo;

   localparam int AW    = 12;
   localparam int DW    = 16;
   localparam int DEPTH = 4096;
   localparam int FW    = 900;
`ifdef PIXEL_FIFO_FRAME_READY_EN
   localparam bit FRAME_EN = 1'b1;
`else
   localparam bit FRAME_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, clear, wr_en, rd_en;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] rd_data;
   logic          rd_data_valid, full, empty, overflow, underflow, frame_ready;
   logic [AW:0]   full_count;

   always #5 clk = ~clk;

   pixel_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_WORDS(FW)) dut (
      .clk           (clk),
      .reset         (reset),
      .wr_data       (wr_data),
      .wr_en         (wr_en),
      .clear         (clear),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .full_count    (full_count),
      .full          (full),
      .empty         (empty),
      .overflow      (overflow),
      .underflow     (underflow),
      .frame_ready   (frame_ready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Scoreboard and reference state
   logic [DW-1:0] sb_q[$];
   logic          m_ovf, m_unf, m_valid, m_frame;
   logic [DW-1:0] m_rd;

   // Drives one cycle of stimulus, advances the reference model across the
   // clock edge, then leaves time 1 unit after the edge for sampling.
   task automatic drive(input logic rst, input logic clr, input logic wr,
                        input logic [DW-1:0] d, input logic rd);
      bit rd_acc, wr_acc;
      int sz;
      reset = rst; clear = clr; wr_en = wr; wr_data = d; rd_en = rd;
      @(posedge clk);
      sz = sb_q.size();
      if (rst) begin
         sb_q.delete();
         m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0; m_rd = '0; m_frame = 1'b0;
      end else begin
         m_frame = FRAME_EN && (sz >= FW);
         if (clr) begin
            sb_q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
         end else begin
            rd_acc = rd && (sz != 0);
            wr_acc = wr && ((sz < DEPTH) || rd_acc);
            if (rd && sz == 0) m_unf = 1'b1;
            if (wr && !wr_acc) m_ovf = 1'b1;
            m_valid = rd_acc;
            if (rd_acc) m_rd = sb_q.pop_front();
            if (wr_acc) sb_q.push_back(d);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 16'h0, 0);
      drive(1, 0, 0, 16'h0, 0);
      drive(0, 0, 0, 16'h0, 0);
      n_checks++;
      if (full_count !== 13'd0) begin
         n_fail++; $display("FAIL reset_count actual=%0d required=0", full_count);
      end
      n_checks++;
      if (rd_data !== 16'h0) begin
         n_fail++; $display("FAIL reset_rd_data actual=%h required=0000", rd_data);
      end
      n_checks++;
      if ({empty, full, rd_data_valid, overflow, underflow, frame_ready} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_flags actual=%b required=100000",
                  {empty, full, rd_data_valid, overflow, underflow, frame_ready});
      end
   endtask

   task automatic test_basic();
      for (int i = 1; i <= 5; i++) drive(0, 0, 1, DW'(i), 0);
      drive(0, 0, 0, 16'h0, 0);
      n_checks++;
      if (full_count !== 13'd5) begin
         n_fail++; $display("FAIL basic_count5 actual=%0d required=5", full_count);
      end
      for (int i = 1; i <= 5; i++) begin
         drive(0, 0, 0, 16'h0, 1);
         n_checks++;
         if (rd_data_valid !== 1'b1 || rd_data !== m_rd || m_rd !== DW'(i)) begin
            n_fail++;
            $display("FAIL basic_read%0d actual=%b/%h required=1/%h", i, rd_data_valid, rd_data, DW'(i));
         end
      end
      drive(0, 0, 0, 16'h0, 0);
      n_checks++;
      if (rd_data_valid !== 1'b0 || full_count !== 13'd0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_end actual=valid%b cnt%0d empty%b required=valid0 cnt0 empty1",
                  rd_data_valid, full_count, empty);
      end
   endtask

   task automatic test_full_wrap();
      int bad;
      logic [DW-1:0] last;
      for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, DW'($urandom), 0);
      n_checks++;
      if (full !== 1'b1 || full_count !== 13'd4096 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL full_fill actual=full%b cnt%0d ovf%b required=full1 cnt4096 ovf0",
                  full, full_count, overflow);
      end
      // Simultaneous write and read on a full FIFO
      drive(0, 0, 1, 16'h5A5A, 1);
      n_checks++;
      if (full_count !== 13'd4096 || overflow !== 1'b0 || rd_data_valid !== 1'b1 || rd_data !== m_rd) begin
         n_fail++;
         $display("FAIL full_rw actual=cnt%0d ovf%b v%b d%h required=cnt4096 ovf0 v1 d%h",
                  full_count, overflow, rd_data_valid, rd_data, m_rd);
      end
      // Extra write is dropped
      drive(0, 0, 1, 16'hDEAD, 0);
      n_checks++;
      if (full !== 1'b1 || overflow !== 1'b1 || full_count !== 13'd4096) begin
         n_fail++;
         $display("FAIL full_overflow actual=full%b ovf%b cnt%0d required=full1 ovf1 cnt4096",
                  full, overflow, full_count);
      end
      last = sb_q[$];
      bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 16'h0, 1);
         n_checks++;
         if (rd_data_valid !== 1'b1 || rd_data !== m_rd) begin
            n_fail++;
            if (bad < 5) $display("FAIL drain_word%0d actual=%b/%h required=1/%h", i, rd_data_valid, rd_data, m_rd);
            bad++;
         end
      end
      n_checks++;
      if (rd_data !== last || last !== 16'h5A5A || empty !== 1'b1 || full_count !== 13'd0) begin
         n_fail++;
         $display("FAIL drain_last actual=%h empty%b cnt%0d required=5a5a empty1 cnt0", rd_data, empty, full_count);
      end
   endtask

   task automatic test_underflow();
      drive(0, 1, 0, 16'h0, 0);
      drive(0, 0, 0, 16'h0, 1);
      n_checks++;
      if (underflow !== 1'b1 || rd_data_valid !== 1'b0) begin
         n_fail++; $display("FAIL underflow actual=unf%b v%b required=unf1 v0", underflow, rd_data_valid);
      end
      drive(0, 0, 1, 16'h1234, 1);
      n_checks++;
      if (full_count !== 13'd1 || rd_data_valid !== 1'b0 || empty !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_rw actual=cnt%0d v%b empty%b required=cnt1 v0 empty0", full_count, rd_data_valid, empty);
      end
      drive(0, 0, 0, 16'h0, 1);
      n_checks++;
      if (rd_data_valid !== 1'b1 || rd_data !== m_rd || m_rd !== 16'h1234) begin
         n_fail++; $display("FAIL empty_rw_read actual=%b/%h required=1/1234", rd_data_valid, rd_data);
      end
   endtask

   task automatic test_frame_ready();
      drive(0, 1, 0, 16'h0, 0);
      for (int i = 0; i < FW - 1; i++) drive(0, 0, 1, DW'(i), 0);
      drive(0, 0, 0, 16'h0, 0);
      n_checks++;
      if (frame_ready !== 1'b0 || frame_ready !== m_frame) begin
         n_fail++; $display("FAIL frame_899 actual=%b required=0", frame_ready);
      end
      drive(0, 0, 1, 16'hF00D, 0);
      n_checks++;
      if (frame_ready !== 1'b0 || full_count !== 13'd900) begin
         n_fail++; $display("FAIL frame_900_early actual=fr%b cnt%0d required=fr0 cnt900", frame_ready, full_count);
      end
      drive(0, 0, 0, 16'h0, 0);
      n_checks++;
      if (frame_ready !== FRAME_EN || frame_ready !== m_frame) begin
         n_fail++; $display("FAIL frame_900 actual=%b required=%b", frame_ready, FRAME_EN);
      end
      drive(0, 0, 0, 16'h0, 1);
      drive(0, 0, 0, 16'h0, 0);
      n_checks++;
      if (frame_ready !== 1'b0 || frame_ready !== m_frame) begin
         n_fail++; $display("FAIL frame_after_read actual=%b required=0", frame_ready);
      end
   endtask

   task automatic test_clear();
      drive(0, 1, 0, 16'h0, 0);
      drive(0, 0, 0, 16'h0, 1);   // sets underflow so clear has a flag to drop
      for (int i = 0; i < 10; i++) drive(0, 0, 1, DW'(16'h100 + i), 0);
      drive(0, 1, 1, 16'h7777, 1);
      n_checks++;
      if (full_count !== 13'd0 || empty !== 1'b1 || rd_data_valid !== 1'b0 ||
          overflow !== 1'b0 || underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL clear actual=cnt%0d e%b v%b o%b u%b required=cnt0 e1 v0 o0 u0",
                  full_count, empty, rd_data_valid, overflow, underflow);
      end
      drive(0, 0, 1, 16'hABCD, 0);
      drive(0, 0, 0, 16'h0, 1);
      n_checks++;
      if (rd_data_valid !== 1'b1 || rd_data !== 16'hABCD || rd_data !== m_rd) begin
         n_fail++; $display("FAIL clear_roundtrip actual=%b/%h required=1/abcd", rd_data_valid, rd_data);
      end
   endtask

   task automatic test_reset_read();
      drive(0, 0, 1, 16'h1111, 0);
      drive(0, 0, 1, 16'h2222, 0);
      drive(1, 0, 0, 16'h0, 1);
      n_checks++;
      if (rd_data_valid !== 1'b0 || full_count !== 13'd0) begin
         n_fail++; $display("FAIL reset_read actual=v%b cnt%0d required=v0 cnt0", rd_data_valid, full_count);
      end
      drive(0, 0, 0, 16'h0, 0);
      n_checks++;
      if (rd_data_valid !== m_valid || rd_data_valid !== 1'b0 || empty !== 1'b1) begin
         n_fail++; $display("FAIL reset_read_after actual=v%b e%b required=v0 e1", rd_data_valid, empty);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_wrap();
      test_underflow();
      test_frame_ready();
      test_clear();
      test_reset_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
